// File: rtl/wei_serial_feeder.sv
// Weight serial feeder: accepts one 3x3 kernel (mask + packed weights), streams its
// nonzero weights one per cycle and publishes per-row counts and column indices.
module wei_serial_feeder #(
    parameter int DATA_WIDTH      = 8,
    parameter int WEI_INDEX_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [8:0]                   in_flag,
    input  logic [DATA_WIDTH*9-1:0]      in_data,
    input  logic                         kernel_release,
    output logic [DATA_WIDTH-1:0]        column_out_serial,
    output logic                         flag_serial,
    output logic                         finish_wei,
    output logic [WEI_INDEX_WIDTH*3-1:0] valid_row,
    output logic [WEI_INDEX_WIDTH*9-1:0] wei_index_full
);

    localparam int DW = DATA_WIDTH;
    localparam int IW = WEI_INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DONE     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [3:0]          nnz_q, nnz_d;
    logic [DW*9-1:0]     data_q, data_d;
    logic [IW*3-1:0]     vr_q, vr_d;
    logic [IW*9-1:0]     wi_q, wi_d;
    logic [DW-1:0]       col_q, col_d;
    logic                flag_q, flag_d;
    logic                fin_q, fin_d;

    logic [8:0]          eff_mask;
    logic [IW*3-1:0]     mask_vr;
    logic [IW*9-1:0]     mask_wi;
    logic [3:0]          mask_nnz;

    assign eff_mask = mode ? in_flag : 9'h1FF;

    // Walk the mask in row-major order: the n-th set bit lands in index slot n.
    always_comb begin
        int n;
        n        = 0;
        mask_vr  = '0;
        mask_wi  = '0;
        for (int b = 0; b < 9; b++) begin
            if (eff_mask[b]) begin
                mask_wi[n*IW +: IW]     = IW'(b % 3);
                mask_vr[(b/3)*IW +: IW] = mask_vr[(b/3)*IW +: IW] + IW'(1);
                n++;
            end
        end
        mask_nnz = 4'(n);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        nnz_d   = nnz_q;
        data_d  = data_q;
        vr_d    = vr_q;
        wi_d    = wi_q;
        col_d   = col_q;
        flag_d  = 1'b0;
        fin_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    vr_d    = mask_vr;
                    wi_d    = mask_wi;
                    nnz_d   = mask_nnz;
                    k_d     = 4'd0;
                    state_d = (mask_nnz != 4'd0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                k_d = k_q + 4'd1;
                if (k_q == nnz_q - 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = kernel_release ? IDLE : WAIT_REL;
            end
            WAIT_REL: begin
                if (kernel_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == STREAM) begin
            flag_d = 1'b1;
            col_d  = data_d[int'(k_d)*DW +: DW];
        end
        if (state_d == DONE) begin
            fin_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            nnz_q   <= '0;
            data_q  <= '0;
            vr_q    <= '0;
            wi_q    <= '0;
            col_q   <= '0;
            flag_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            nnz_q   <= nnz_d;
            data_q  <= data_d;
            vr_q    <= vr_d;
            wi_q    <= wi_d;
            col_q   <= col_d;
            flag_q  <= flag_d;
            fin_q   <= fin_d;
        end
    end

    assign in_ready          = (state_q == IDLE) && !reset;
    assign column_out_serial = col_q;
    assign flag_serial       = flag_q;
    assign finish_wei        = fin_q;
    assign valid_row         = vr_q;
    assign wei_index_full    = wi_q;

endmodule

// File: tb/tb_wei_serial_feeder.sv
// Scoreboard bench for wei_serial_feeder: stimulus pushes expected bytes/finish records,
// a negedge monitor pops and compares them against the serial outputs.
module tb_wei_serial_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_flag;
    logic [71:0] in_data;
    logic        kernel_release;
    logic [7:0]  column_out_serial;
    logic        flag_serial;
    logic        finish_wei;
    logic [5:0]  valid_row;
    logic [17:0] wei_index_full;

    wei_serial_feeder dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_flag           (in_flag),
        .in_data           (in_data),
        .kernel_release    (kernel_release),
        .column_out_serial (column_out_serial),
        .flag_serial       (flag_serial),
        .finish_wei        (finish_wei),
        .valid_row         (valid_row),
        .wei_index_full    (wei_index_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } byte_t;

    typedef struct {
        int          cyc;
        logic [5:0]  vr;
        logic [17:0] wi;
    } fin_t;

    byte_t bq[$];
    fin_t  fq[$];
    bit    rel_at[int];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int next_exp = 0;
    int last_t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) kernel_release = rel_at.exists(cyc);

    // Monitor: pops expectations whenever the DUT presents a byte or a finish pulse.
    always @(negedge clk) begin
        if (!reset) begin
            while (bq.size() > 0 && bq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL byte_missing: expected 0x%0h at cycle %0d, nothing seen", bq[0].data, bq[0].cyc);
                void'(bq.pop_front());
            end
            while (fq.size() > 0 && fq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL finish_missing: expected finish at cycle %0d, finish_wei not observed", fq[0].cyc);
                void'(fq.pop_front());
            end
            if (flag_serial) begin
                checks++;
                if (bq.size() == 0 || bq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL byte_unexpected: got 0x%0h at cycle %0d, no byte expected", column_out_serial, cyc);
                end else begin
                    byte_t b;
                    b = bq.pop_front();
                    if (column_out_serial !== b.data) begin
                        errors++;
                        $display("FAIL byte_value: cycle %0d got 0x%0h expected 0x%0h", cyc, column_out_serial, b.data);
                    end
                end
            end
            if (finish_wei) begin
                checks++;
                if (fq.size() == 0 || fq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL finish_unexpected: finish_wei at cycle %0d not expected", cyc);
                end else begin
                    fin_t f;
                    f = fq.pop_front();
                    if (valid_row !== f.vr || wei_index_full !== f.wi) begin
                        errors++;
                        $display("FAIL kernel_meta: cycle %0d valid_row got %b expected %b, wei_index_full got %b expected %b",
                                 cyc, valid_row, f.vr, wei_index_full, f.wi);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a kernel, push its expectations, and schedule the consumer release.
    // rel_off = cycles after DONE at which release is sampled high; stray = extra release during STREAM.
    task automatic send(input logic md, input logic [8:0] flg, input logic [71:0] dat,
                        input int nnz, input logic [5:0] vr, input logic [17:0] wi,
                        input int rel_off, input bit stray, input bit chk_acc);
        int n;
        int t;
        mode = md; in_flag = flg; in_data = dat; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose, got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        if (chk_acc) chk("accept_cycle", 72'(t), 72'(next_exp));
        for (int k = 0; k < nnz; k++) bq.push_back('{cyc: t + k, data: dat[k*8 +: 8]});
        fq.push_back('{cyc: t + nnz, vr: vr, wi: wi});
        rel_at[t + nnz + rel_off] = 1'b1;
        if (stray) rel_at[t + 1] = 1'b1;
        next_exp = t + nnz + rel_off + 2;
        last_t = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_flag = '0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 72'(in_ready), 72'd0);
        chk("rst_outputs", {column_out_serial, flag_serial, finish_wei, valid_row, wei_index_full}, 72'd0);
        #2 reset = 1'b0;
        #1 chk("rst_ready_after", 72'(in_ready), 72'd1);
        @(negedge clk);

        // dense 1..9
        send(1'b0, 9'h000, 72'h09_08_07_06_05_04_03_02_01, 9, 6'b11_11_11,
             18'b10_01_00_10_01_00_10_01_00, 0, 1'b0, 1'b0);
        // sparse, back-to-back after DONE-cycle release; stray release mid-stream, late release
        send(1'b1, 9'b100_000_011, 72'hEE_EE_EE_EE_EE_EE_0C_0B_0A, 3, 6'b01_00_10,
             18'h00024, 5, 1'b1, 1'b1);
        // empty mask
        send(1'b1, 9'h000, 72'h55_55_55_55_55_55_55_55_55, 0, 6'b0, 18'h0, 0, 1'b0, 1'b1);
        // dense mode ignores in_flag
        send(1'b0, 9'h0A5, 72'h99_88_77_66_55_44_33_22_11, 9, 6'b11_11_11,
             18'b10_01_00_10_01_00_10_01_00, 0, 1'b0, 1'b1);
        // sparse, five nonzeros across all rows
        send(1'b1, 9'b010_111_001, 72'hEE_EE_EE_EE_65_54_43_32_21, 5, 6'b01_11_01,
             18'h00190, 2, 1'b0, 1'b1);
        // dense stream aborted by reset at its 4th byte
        send(1'b0, 9'h000, 72'hF9_F8_F7_F6_F5_F4_F3_F2_F1, 9, 6'b11_11_11,
             18'b10_01_00_10_01_00_10_01_00, 100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        bq.delete(); fq.delete(); rel_at.delete();
        #1 chk("abort_outputs", {column_out_serial, flag_serial, finish_wei}, 72'd0);
        chk("abort_in_ready", 72'(in_ready), 72'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("abort_ready_after", 72'(in_ready), 72'd1);
        chk("abort_meta_cleared", {valid_row, wei_index_full}, 72'd0);
        @(negedge clk);
        chk("abort_no_finish", 72'(finish_wei), 72'd0);
        // normal kernel after the abort
        send(1'b1, 9'b100_000_011, 72'hEE_EE_EE_EE_EE_EE_3C_2B_1A, 3, 6'b01_00_10,
             18'h00024, 0, 1'b0, 1'b0);
        chk("post_abort_accept", 72'(last_t), 72'(cyc));

        repeat (30) @(negedge clk);
        chk("pending_bytes", 72'(bq.size()), 72'd0);
        chk("pending_finish", 72'(fq.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wei_serial_feeder.md
# wei_serial_feeder

Transmit side of the weight serial stream in the PE weight path. Accepts one 3x3 kernel per handshake as a sparsity mask plus packed nonzero weights. Streams the weights one byte per cycle on `column_out_serial`/`flag_serial`, then pulses `finish_wei`. Publishes the per-row nonzero counts (`valid_row`) and the column index of every nonzero weight (`wei_index_full`) for the downstream serializer, and holds them until the consumer releases the kernel.

## Interface
- `DATA_WIDTH`, default 8, is the width of one weight.
- `WEI_INDEX_WIDTH`, default 2, is the width of one column index and of one row count.

- `clk`  in  1  is the single clock.
- `reset`  in  1  is the reset: asynchronous, active-high.
- `mode`  in  1  selects the stream mode: 1 = sparse (use mask), 0 = dense (all 9 weights). Sampled only at accept.
- `in_valid`  in  1  means a kernel descriptor is offered.
- `in_ready`  out  1  means the block can accept a kernel.
- `in_flag`  in  9  is the sparsity mask; bit r*3+c is row r, column c.
- `in_data`  in  DATA_WIDTH*9  holds the weights. Sparse: the nonzeros are packed from slot 0 upward in row-major order. Dense: slot r*3+c.
- `kernel_release`  in  1  is a pulse from the consumer saying the current kernel is no longer needed.
- `column_out_serial`  out  DATA_WIDTH  is the streamed weight.
- `flag_serial`  out  1  is high when `column_out_serial` is valid.
- `finish_wei`  out  1  is a one-cycle pulse after the last weight of the kernel.
- `valid_row`  out  WEI_INDEX_WIDTH*3  holds the nonzero count of row r in field r.
- `wei_index_full`  out  WEI_INDEX_WIDTH*9  holds, in slot n, the column of the n-th streamed weight. Unused slots are 0.

## Operation
- The FSM has four states: IDLE, STREAM, DONE, WAIT_REL.
- `in_ready` = (state == IDLE). It is forced to 0 while `reset` is asserted.
- **IDLE.** On `in_valid & in_ready`, the block captures `in_data` and the effective mask, where the effective mask is `in_flag` (mode 1) or 9'h1FF (mode 0).
  - In the same edge it registers `valid_row`: field r = popcount(mask[3r+2:3r]).
  - It registers `nnz` = popcount(mask), range 0..9, held in 4 bits.
  - It registers `wei_index_full`: the n-th set bit in row-major order gives slot n = its column. Slots n >= nnz are 0.
  - It clears the byte counter k. Next state is STREAM if nnz > 0, else DONE.
- **STREAM.** Each cycle the block drives `column_out_serial` = slot k of the captured data and `flag_serial` = 1, then increments k. When k == nnz-1 the next state is DONE.
- **DONE.** For one cycle: `finish_wei` = 1, `flag_serial` = 0, `column_out_serial` holds its last value. If `kernel_release` is high in this cycle, the next state is IDLE; otherwise it is WAIT_REL.
- **WAIT_REL.** The block waits for `kernel_release`, then goes to IDLE.
- `kernel_release` is ignored in IDLE and STREAM.
- `valid_row` and `wei_index_full` hold from the accept edge until the next accept. They are never cleared between kernels.
- All outputs are registered except `in_ready`.

## Timing
- **Reset values.** State is IDLE. `column_out_serial`, `flag_serial`, `finish_wei`, `valid_row`, `wei_index_full` and k are all 0.
- **Accept at edge T:**
  - First weight is valid in cycle T+1.
  - Weight k is valid in cycle T+1+k.
  - `finish_wei` is high in cycle T+1+nnz (T+1 when nnz = 0).
  - `valid_row`/`wei_index_full` are valid from T+1.
- `flag_serial` is high for exactly nnz consecutive cycles per kernel, with no gaps and no backpressure.
- **Minimum kernel period:** nnz+2 cycles, reached when `kernel_release` is high in the DONE cycle and `in_valid` is high in the following IDLE cycle.
- **Reset mid-operation:** the block returns to IDLE immediately. No `finish_wei` is issued for the aborted kernel, the partial stream is discarded and the outputs go to 0.
- `in_valid` while not ready has no effect. The offering side holds the descriptor until it is accepted.

## Test plan
- **Dense kernel.** mode 0, data bytes 1..9 -> `flag_serial` high for 9 cycles T+1..T+9 emitting 1..9; `finish_wei` at T+10; `valid_row` = {3,3,3}; `wei_index_full` = {2,1,0,2,1,0,2,1,0} (slot 8..0).
- **Sparse kernel.** mode 1, `in_flag` = 9'b100_000_011, data slots {0xA,0xB,0xC} -> stream 0xA, 0xB, 0xC over 3 cycles; `finish_wei` at T+4; `valid_row` row0=2, row1=0, row2=1; `wei_index_full` slots 0..2 = {0,1,2}, remaining slots 0.
- **Empty mask.** mode 1, `in_flag` = 0 -> no `flag_serial` pulse; `finish_wei` at T+1; `valid_row` = 0; `wei_index_full` = 0.
- **Release timing.** `kernel_release` in the DONE cycle with back-to-back `in_valid` -> second accept at T+nnz+2. A release first asserted 5 cycles after DONE delays the next accept to match; a release pulse during STREAM is ignored and the block waits in WAIT_REL.
- **Reset mid-stream.** Assert `reset` at the 4th byte of a 9-byte stream -> `flag_serial` goes to 0 immediately; no `finish_wei`; `in_ready` is 1 after release of reset; the next kernel streams normally.
